// File: rtl/blit_arbiter_if.sv
// Blitter-side command bus: registered command fields, start pulse, and the
// blitter's ready/collision status returned to the arbiter.
interface blit_arbiter_if;
    logic [2:0]  blit_op;
    logic [11:0] blit_src;
    logic [3:0]  blit_srcHeight;
    logic [6:0]  blit_destX;
    logic [5:0]  blit_destY;
    logic        blit_enable;
    logic        blit_ready;
    logic        blit_collision;

    modport master (
        output blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable,
        input  blit_ready, blit_collision
    );

    modport slave (
        input  blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable,
        output blit_ready, blit_collision
    );
endinterface

// File: rtl/blit_arbiter.sv
// Round-robin arbiter sharing one sprite blitter between two requesters.
// state     | meaning
// IDLE      | waiting for a request while the blitter reports ready
// ISSUE     | command registered, blit_enable pulsed
// WAIT_BUSY | waiting for blitter to drop ready, bounded by BUSY_TIMEOUT
// WAIT_DONE | blitter busy, waiting for ready to return
// RESP      | done pulse to the granted requester
module blit_arbiter #(
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [11:0] req0_src,
    input  logic [3:0]  req0_height,
    input  logic [6:0]  req0_x,
    input  logic [5:0]  req0_y,
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [11:0] req1_src,
    input  logic [3:0]  req1_height,
    input  logic [6:0]  req1_x,
    input  logic [5:0]  req1_y,
    output logic        req0_accept,
    output logic        req0_done,
    output logic        req0_collision,
    output logic        req1_accept,
    output logic        req1_done,
    output logic        req1_collision,
    output logic        busy,
    blit_arbiter_if.master blit
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  coll_q, coll_d;
    logic [2:0]  op_q, op_d;
    logic [11:0] src_q, src_d;
    logic [3:0]  height_q, height_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic [1:0]  accept;
    logic        sel1;

    // req1 wins when it is alone or when req0 was served last
    assign sel1 = req1_valid && (!req0_valid || !last_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        coll_d   = coll_q;
        op_d     = op_q;
        src_d    = src_q;
        height_d = height_q;
        x_d      = x_q;
        y_d      = y_q;
        accept   = 2'b00;
        case (state_q)
            IDLE: begin
                if (reset_n && blit.blit_ready && (req0_valid || req1_valid)) begin
                    gnt_d       = sel1;
                    last_d      = sel1;
                    accept[sel1] = 1'b1;
                    op_d        = sel1 ? req1_op     : req0_op;
                    src_d       = sel1 ? req1_src    : req0_src;
                    height_d    = sel1 ? req1_height : req0_height;
                    x_d         = sel1 ? req1_x      : req0_x;
                    y_d         = sel1 ? req1_y      : req0_y;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!blit.blit_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        coll_d[gnt_q] = blit.blit_collision;
                        state_d       = RESP;
                    end
                end
            end
            WAIT_DONE: begin
                if (blit.blit_ready) begin
                    coll_d[gnt_q] = blit.blit_collision;
                    state_d       = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            coll_q   <= '0;
            op_q     <= '0;
            src_q    <= '0;
            height_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            coll_q   <= coll_d;
            op_q     <= op_d;
            src_q    <= src_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign req0_accept    = accept[0];
    assign req1_accept    = accept[1];
    assign req0_done      = (state_q == RESP) && !gnt_q;
    assign req1_done      = (state_q == RESP) && gnt_q;
    assign req0_collision = coll_q[0];
    assign req1_collision = coll_q[1];
    assign busy           = (state_q != IDLE);

    assign blit.blit_enable    = (state_q == ISSUE);
    assign blit.blit_op        = op_q;
    assign blit.blit_src       = src_q;
    assign blit.blit_srcHeight = height_q;
    assign blit.blit_destX     = x_q;
    assign blit.blit_destY     = y_q;
endmodule

// File: doc/blit_arbiter.md
BLIT_ARBITER -- requirements
Module: blit_arbiter

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 15: max cycles to wait for blit_ready to drop after issue.
REQ-002 SHALL have port clk  in  1  blitter clock domain (blit_clk); the single clock.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  in  1  each: requester N has a command pending.
REQ-005 SHALL have ports reqN_op  in  3  blitter operation code.
REQ-006 SHALL have ports reqN_src  in  12  sprite source address in CPU RAM.
REQ-007 SHALL have ports reqN_height  in  4  sprite height in rows.
REQ-008 SHALL have ports reqN_x  in  7  destination X.
REQ-009 SHALL have ports reqN_y  in  6  destination Y.
REQ-010 SHALL have ports reqN_accept  out  1  one-cycle pulse: command N captured.
REQ-011 SHALL have ports reqN_done  out  1  one-cycle pulse: command N completed.
REQ-012 SHALL have ports reqN_collision  out  1  collision result for N, valid with reqN_done and held until N's next done.
REQ-013 SHALL have ports blit_op 3, blit_src 12, blit_srcHeight 4, blit_destX 7, blit_destY 6  out  registered command to blitter.
REQ-014 SHALL have port blit_enable  out  1  one-cycle start pulse to blitter.
REQ-015 SHALL have ports blit_ready  in  1  (high = blitter idle) and blit_collision  in  1  (valid when blit_ready rises).
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 IDLE: if any reqN_valid and blit_ready=1, SHALL grant one, register its command fields into blit_* outputs, pulse reqN_accept that cycle, go ISSUE.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; after reset, last-granted = 1 (req0 wins first tie).
REQ-020 With one valid, SHALL grant it regardless of round-robin pointer; pointer updates to the granted index.
REQ-021 IDLE with blit_ready=0 SHALL not grant; remain IDLE.
REQ-022 ISSUE: SHALL assert blit_enable exactly one cycle, go WAIT_BUSY, clear timeout counter.
REQ-023 WAIT_BUSY: blit_ready=0 -> WAIT_DONE; else counter increments; counter reaching BUSY_TIMEOUT -> RESP with collision taken as blit_collision that cycle.
REQ-024 WAIT_DONE: on blit_ready=1, SHALL capture blit_collision into granted reqN_collision, go RESP.
REQ-025 RESP: SHALL pulse granted reqN_done one cycle, go IDLE; earliest next grant is the following cycle.
REQ-026 Issue-to-done latency: accept at cycle T, blit_enable at T+1, done at (ready-rise cycle)+1.
REQ-027 blit_* command outputs SHALL stay constant from grant until return to IDLE.
REQ-028 reqN_valid changes while not granted SHALL have no effect; deassertion of the granted reqN_valid after accept SHALL not abort the blit.
REQ-029 Non-granted requester SHALL see no accept, done, or collision change.
REQ-030 Timeout counter SHALL be wide enough for BUSY_TIMEOUT and SHALL not wrap.

Reset
REQ-031 reset_n=0 at a clk edge SHALL force IDLE, last-granted=1, counter=0; blit_enable, reqN_accept, reqN_done, busy = 0; reqN_collision = 0; blit_* fields = 0.
REQ-032 Reset mid-blit SHALL abandon the command with no reqN_done; blitter not separately signalled.

Verification
REQ-033 req0 valid alone, blitter drops ready 2 cycles after enable, holds low 10 cycles, collision=1 -> req0_accept at T, blit_enable at T+1, req0_done with req0_collision=1 one cycle after ready rises; req1 outputs unchanged.
REQ-034 Both valid continuously from reset, 4 blits -> grant order 0,1,0,1; blit_* match each requester's fields.
REQ-035 blit_ready never drops after enable -> done pulse at BUSY_TIMEOUT+1 cycles after enable, arbiter returns IDLE.
REQ-036 req1 valid while blit_ready=0 in IDLE -> no accept until ready=1, then accept next edge.
REQ-037 reset_n low during WAIT_DONE -> next cycle busy=0, no done pulse, after release both valid -> req0 granted.
